// File: rtl/hsl_to_rgb_pkg.sv
// Shared constants, sector encodings and pipeline stage payloads for hsl_to_rgb.
package hsl_to_rgb_pkg;

  localparam int unsigned HSL_W      = 10;
  localparam int unsigned RGB_W      = 8;
  localparam int unsigned HUE_SECTOR = 128;
  localparam int unsigned HUE_WRAP   = 768;
  localparam int unsigned HSL_HALF   = 1 << (HSL_W - 1);
  localparam int unsigned FRAC_W     = 7;
  localparam int unsigned SUM_W      = HSL_W + 1;
  localparam int unsigned CPROD_W    = 2 * HSL_W;
  localparam int unsigned XPROD_W    = HSL_W + FRAC_W + 1;

  // Hue sector encodings, hw[9:7] of the wrapped hue.
  typedef enum logic [2:0] {
    SEC_RED_YEL = 3'd0,
    SEC_YEL_GRN = 3'd1,
    SEC_GRN_CYN = 3'd2,
    SEC_CYN_BLU = 3'd3,
    SEC_BLU_MAG = 3'd4,
    SEC_MAG_RED = 3'd5
  } sector_t;

  // Stage 1: wrapped hue, chroma base and pass-through operands.
  typedef struct packed {
    logic [HSL_W-1:0] hw;
    logic [HSL_W-1:0] cb;
    logic [HSL_W-1:0] sat;
    logic [HSL_W-1:0] light;
  } s1_t;

  // Stage 2: chroma.
  typedef struct packed {
    logic [HSL_W-1:0] hw;
    logic [HSL_W-1:0] c;
    logic [HSL_W-1:0] light;
  } s2_t;

  // Stage 3: operands for the sector mix.
  typedef struct packed {
    sector_t          sector;
    logic [HSL_W-1:0] c;
    logic [HSL_W-1:0] x;
    logic [HSL_W-1:0] m;
  } s3_t;

endpackage

// File: rtl/hsl_sector_mix.sv
// Combinational sector mux, lightness offset add and clamp for the last stage.
// Ports: sector/c/x/m operands in; r_c/g_c/b_c 8-bit channels out.
module hsl_sector_mix
  import hsl_to_rgb_pkg::*;
(
  input  sector_t          sector,
  input  logic [HSL_W-1:0] c,
  input  logic [HSL_W-1:0] x,
  input  logic [HSL_W-1:0] m,
  output logic [RGB_W-1:0] r_c,
  output logic [RGB_W-1:0] g_c,
  output logic [RGB_W-1:0] b_c
);

  logic [HSL_W-1:0] rp, gp, bp;

  // Add offset with one guard bit, saturate to full scale, keep top 8 bits.
  function automatic logic [RGB_W-1:0] mix_chan(input logic [HSL_W-1:0] chan,
                                                input logic [HSL_W-1:0] off);
    logic [SUM_W-1:0] sum;
    logic [HSL_W-1:0] clamped;
    sum     = SUM_W'(chan) + SUM_W'(off);
    clamped = sum[SUM_W-1] ? {HSL_W{1'b1}} : HSL_W'(sum);
    return RGB_W'(clamped >> (HSL_W - RGB_W));
  endfunction

  // Place C and X on the channels selected by the hue sector.
  always_comb begin
    rp = '0;
    gp = '0;
    bp = '0;
    case (sector)
      SEC_RED_YEL: begin rp = c; gp = x; end
      SEC_YEL_GRN: begin rp = x; gp = c; end
      SEC_GRN_CYN: begin gp = c; bp = x; end
      SEC_CYN_BLU: begin gp = x; bp = c; end
      SEC_BLU_MAG: begin rp = x; bp = c; end
      SEC_MAG_RED: begin rp = c; bp = x; end
      default:     begin rp = '0; gp = '0; bp = '0; end
    endcase
  end

  assign r_c = mix_chan(rp, m);
  assign g_c = mix_chan(gp, m);
  assign b_c = mix_chan(bp, m);

endmodule

// File: rtl/hsl_to_rgb.sv
// Four-stage HSL to RGB converter with valid/ready flow control.
// Ports: clk, reset (sync, active-high); in_valid/in_ready with hue,
// saturation, lightness (10 bits); out_valid/out_ready with r, g, b (8 bits).
module hsl_to_rgb
  import hsl_to_rgb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [HSL_W-1:0] hue,
  input  logic [HSL_W-1:0] saturation,
  input  logic [HSL_W-1:0] lightness,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RGB_W-1:0] r,
  output logic [RGB_W-1:0] g,
  output logic [RGB_W-1:0] b
);

  logic advance;
  logic v1, v2, v3;
  s1_t  s1, s1_next;
  s2_t  s2, s2_next;
  s3_t  s3, s3_next;

  logic [HSL_W-1:0]   light_inv;
  logic [CPROD_W-1:0] c_prod;
  logic [FRAC_W-1:0]  frac;
  logic [FRAC_W:0]    f;
  logic [XPROD_W-1:0] x_prod;
  logic [RGB_W-1:0]   r_c, g_c, b_c;

  // Whole pipeline moves together unless a held output is blocking it.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage 1 operands: wrap hue, fold lightness around mid-scale.
  assign light_inv = ~lightness;
  always_comb begin
    s1_next       = '0;
    s1_next.hw    = (hue >= HSL_W'(HUE_WRAP)) ? hue - HSL_W'(HUE_WRAP) : hue;
    s1_next.cb    = (lightness < HSL_W'(HSL_HALF)) ? {lightness[HSL_W-2:0], 1'b0}
                                                    : {light_inv[HSL_W-2:0], 1'b0};
    s1_next.sat   = saturation;
    s1_next.light = lightness;
  end

  // Stage 2 operands: chroma is the top half of cb * saturation.
  assign c_prod = CPROD_W'(s1.cb) * CPROD_W'(s1.sat);
  always_comb begin
    s2_next       = '0;
    s2_next.hw    = s1.hw;
    s2_next.c     = HSL_W'(c_prod >> HSL_W);
    s2_next.light = s1.light;
  end

  // Stage 3 operands: odd sectors ramp down, so mirror the fraction.
  assign frac   = s2.hw[FRAC_W-1:0];
  assign f      = s2.hw[FRAC_W] ? (FRAC_W+1)'(HUE_SECTOR) - {1'b0, frac} : {1'b0, frac};
  assign x_prod = XPROD_W'(s2.c) * XPROD_W'(f);
  always_comb begin
    s3_next        = '0;
    s3_next.sector = sector_t'(s2.hw[HSL_W-1:FRAC_W]);
    s3_next.c      = s2.c;
    s3_next.x      = HSL_W'(x_prod >> FRAC_W);
    // C/2 never exceeds lightness by construction of cb.
    s3_next.m      = s2.light - {1'b0, s2.c[HSL_W-1:1]};
  end

  hsl_sector_mix u_mix (
    .sector (s3.sector),
    .c      (s3.c),
    .x      (s3.x),
    .m      (s3.m),
    .r_c    (r_c),
    .g_c    (g_c),
    .b_c    (b_c)
  );

  // Stage registers; data only loads with valid data so outputs hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (in_valid) s1 <= s1_next;
      if (v1)       s2 <= s2_next;
      if (v2)       s3 <= s3_next;
      if (v3) begin
        r <= r_c;
        g <= g_c;
        b <= b_c;
      end
    end
  end

endmodule

// File: tb/tb_hsl_to_rgb.sv
// Self-checking bench for hsl_to_rgb: directed table, stall/reset sequences,
// and streamed samples against an arithmetic reference model.
module tb_hsl_to_rgb;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] hue;
  logic [9:0] saturation;
  logic [9:0] lightness;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] r, g, b;

  int total = 0;
  int bad   = 0;

  hsl_to_rgb dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hue        (hue),
    .saturation (saturation),
    .lightness  (lightness),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .g          (g),
    .b          (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h;
    int s;
    int l;
    int er;
    int eg;
    int eb;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference conversion written directly in integer arithmetic.
  function automatic void model(input int h, input int s, input int l,
                                output int ro, output int go, output int bo);
    int hw, cb, c, sec, fr, f, x, m, rp, gp, bp;
    hw  = (h >= 768) ? h - 768 : h;
    cb  = (l < 512) ? 2 * l : 2 * (1023 - l);
    c   = (cb * s) / 1024;
    sec = hw / 128;
    fr  = hw % 128;
    f   = (sec % 2 == 1) ? 128 - fr : fr;
    x   = (c * f) / 128;
    m   = l - c / 2;
    rp = 0; gp = 0; bp = 0;
    case (sec)
      0: begin rp = c; gp = x; end
      1: begin rp = x; gp = c; end
      2: begin gp = c; bp = x; end
      3: begin gp = x; bp = c; end
      4: begin rp = x; bp = c; end
      default: begin rp = c; bp = x; end
    endcase
    ro = ((rp + m > 1023) ? 1023 : rp + m) / 4;
    go = ((gp + m > 1023) ? 1023 : gp + m) / 4;
    bo = ((bp + m > 1023) ? 1023 : bp + m) / 4;
  endfunction

  // One isolated sample: must appear exactly on the 4th edge from acceptance.
  task automatic run_one(input int h, input int s, input int l,
                         output int ro, output int go, output int bo);
    int seen;
    @(negedge clk);
    hue = 10'(h); saturation = 10'(s); lightness = 10'(l);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = int'(out_valid);
    repeat (2) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    check("early_valid", seen, 0);
    @(negedge clk);
    check("valid_at_lat4", int'(out_valid), 1);
    ro = int'(r); go = int'(g); bo = int'(b);
  endtask

  // Stream n random samples; toggle selects alternating out_ready.
  task automatic stream(input int n, input bit toggle, input string tag);
    int qr[$], qg[$], qb[$];
    int sent, got, cyc, h, s, l, er, eg, eb;
    bit need_new;
    sent = 0; got = 0; cyc = 0; need_new = 1'b1;
    h = 0; s = 0; l = 0;
    while (got < n && cyc < 20 * n + 50) begin
      @(negedge clk);
      out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (sent < n) begin
        if (need_new) begin
          h = $urandom_range(0, 1023);
          s = $urandom_range(0, 1023);
          l = $urandom_range(0, 1023);
          if (sent == 0) l = 1023;
          if (sent == 1) s = 0;
          need_new = 1'b0;
        end
        hue = 10'(h); saturation = 10'(s); lightness = 10'(l);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({tag, "_in_ready"}, int'(in_ready), int'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        check({tag, "_dup_out"}, int'(qr.size() > 0), 1);
        if (qr.size() > 0) begin
          check({tag, "_r"}, int'(r), qr.pop_front());
          check({tag, "_g"}, int'(g), qg.pop_front());
          check({tag, "_b"}, int'(b), qb.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        model(h, s, l, er, eg, eb);
        qr.push_back(er); qg.push_back(eg); qb.push_back(eb);
        sent++;
        need_new = 1'b1;
      end
      cyc++;
    end
    check({tag, "_count"}, got, n);
    check({tag, "_leftover"}, qr.size(), 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int ar, ag, ab, seen, hr, hg, hb;

    vecs[0]  = '{0,    1023, 512,  255, 0,   0};
    vecs[1]  = '{256,  1023, 512,  0,   255, 0};
    vecs[2]  = '{64,   1023, 512,  255, 128, 0};
    vecs[3]  = '{768,  1023, 512,  255, 0,   0};
    vecs[4]  = '{100,  0,    512,  128, 128, 128};
    vecs[5]  = '{300,  700,  1023, 255, 255, 255};
    vecs[6]  = '{500,  900,  0,    0,   0,   0};
    vecs[7]  = '{512,  1023, 512,  0,   0,   255};
    vecs[8]  = '{128,  1023, 512,  255, 255, 0};
    vecs[9]  = '{1023, 1023, 512,  2,   255, 0};
    vecs[10] = '{0,    512,  256,  96,  32,  32};
    vecs[11] = '{640,  1023, 512,  255, 0,   255};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    hue = '0; saturation = '0; lightness = '0;

    // Reset state, with a sample offered while reset is high.
    @(negedge clk);
    hue = 10'd0; saturation = 10'd1023; lightness = 10'd512; in_valid = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_rgb", int'({r, g, b}), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    check("rst_input_dropped", seen, 0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].h, vecs[i].s, vecs[i].l, ar, ag, ab);
      check($sformatf("vec%0d_r", i), ar, vecs[i].er);
      check($sformatf("vec%0d_g", i), ag, vecs[i].eg);
      check($sformatf("vec%0d_b", i), ab, vecs[i].eb);
    end

    // Stall: output holds, input side blocked; then drain and hold across bubble.
    run_one(64, 1023, 512, hr, hg, hb);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_valid", int'(out_valid), 1);
    check("stall_in_ready", int'(in_ready), 0);
    check("stall_rgb", int'({r, g, b}), (255 << 16) | (128 << 8));
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", int'(out_valid), 0);
    check("bubble_hold_rgb", int'({r, g, b}), (255 << 16) | (128 << 8));

    // Reset with three samples in flight.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      hue = 10'(i * 256); saturation = 10'd1023; lightness = 10'd512;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_rgb", int'({r, g, b}), 0);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    check("midrst_flushed", seen, 0);
    run_one(256, 1023, 512, ar, ag, ab);
    check("post_rst_rgb", (ar << 16) | (ag << 8) | ab, 255 << 8);

    // Throughput with stalls, then a full-rate random sweep.
    stream(10, 1'b1, "toggle");
    stream(300, 1'b0, "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
